// File: rtl/alu_seq_pkg.sv
// Shared types and display helpers for the ALU key sequencer.
// Used by alu_key_sequencer; ALU_SEQ_SIGNED_DISPLAY_EN is consumed in the top.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_MULT = 2'b10
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    SETTLE  = 2'b01,
    CAPTURE = 2'b10,
    HOLD    = 2'b11
  } seq_state_e;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  // Active-low gfedcba pattern for one hex digit
  function automatic logic [6:0] hex_to_seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Single-key conditioner: 2-flop synchroniser followed by a stability counter.
// level follows the synchronised input only after DEBOUNCE_CYCLES consecutive
// samples that disagree with the current level; one agreeing sample restarts.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_n,
  output logic level
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_TC = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic [CW-1:0] cnt_q;
  logic          level_q;

  // Synchronise, count disagreeing samples, flip the level at terminal count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b1;   // released: keys are active-low
    end else begin
      sync1_q <= raw_n;
      sync2_q <= sync1_q;
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_TC) begin
        level_q <= sync2_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign level = level_q;

endmodule

// File: rtl/alu_key_sequencer.sv
// Key-driven initiator for the combinational ALU: debounces three op keys,
// issues the opcode, waits one settle cycle, captures result and flags and
// shows the result on two 7-segment digits.
// Optional: ALU_SEQ_SIGNED_DISPLAY_EN shows a signed magnitude with a minus sign.
//
// state   | meaning
// IDLE    | waiting for a debounced press
// SETTLE  | opcode issued, ALU combinational path settling
// CAPTURE | result/flags registered at the end of this cycle, done high
// HOLD    | waiting for all keys to be released
module alu_key_sequencer
  import alu_seq_pkg::*;
#(
  parameter int N               = 4,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [2:0]   key_n,
  output opcode_e      op,
  input  logic [N-1:0] alu_out,
  input  logic         alu_z,
  input  logic         alu_n,
  input  logic         alu_v,
  input  logic         alu_c,
  output logic [N-1:0] res_q,
  output logic [3:0]   flags_q,
  output logic         done,
  output logic         busy,
  output logic [6:0]   hex0,
  output logic [6:0]   hex1
);

  seq_state_e   state_q, state_d;
  opcode_e      op_q, op_d, op_sel;
  logic [N-1:0] res_d;
  logic [3:0]   flags_d;
  logic [2:0]   level;
  logic [2:0]   press;

  for (genvar i = 0; i < 3; i++) begin : g_deb
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk   (clk),
      .rst_n (rst_n),
      .raw_n (key_n[i]),
      .level (level[i])
    );
  end

  assign press = ~level;

  // Fixed priority Add > Sub > Mult when several keys are down together
  always_comb begin
    op_sel = OP_MULT;
    if (press[2])      op_sel = OP_ADD;
    else if (press[1]) op_sel = OP_SUB;
  end

  // State, opcode and capture registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= OP_ADD;
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      res_q   <= res_d;
      flags_q <= flags_d;
    end
  end

  // Next-state logic; only IDLE looks at new presses, so one capture per press
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    res_d   = res_q;
    flags_d = flags_q;
    case (state_q)
      IDLE: begin
        if (|press) begin
          op_d    = op_sel;
          state_d = SETTLE;
        end
      end
      SETTLE:  state_d = CAPTURE;
      CAPTURE: begin
        res_d   = alu_out;
        flags_d = {alu_n, alu_z, alu_v, alu_c};
        state_d = HOLD;
      end
      HOLD: begin
        if (!(|press)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Status outputs decoded from the current state
  always_comb begin
    done = (state_q == CAPTURE);
    busy = (state_q != IDLE);
  end

  assign op = op_q;

`ifdef ALU_SEQ_SIGNED_DISPLAY_EN
  logic [N-1:0] mag;

  // Two's-complement display: magnitude on hex0, minus on hex1 when negative
  always_comb begin
    mag  = res_q;
    hex1 = SEG_BLANK;
    if (res_q[N-1]) begin
      mag  = -res_q;   // most negative value wraps to itself, shown as 8 with minus
      hex1 = SEG_MINUS;
    end
    hex0 = hex_to_seg7(mag[3:0]);
  end
`else
  // Raw hex display of the low nibble; sign digit unused
  always_comb begin
    hex0 = hex_to_seg7(res_q[3:0]);
    hex1 = SEG_BLANK;
  end
`endif

endmodule

// File: tb/tb_alu_key_sequencer.sv
// Self-checking bench for alu_key_sequencer with a behavioural ALU and a
// transaction-level reference (expected opcode/result per key press).
module tb_alu_key_sequencer;
  import alu_seq_pkg::*;

  localparam int N = 4;

  logic         clk;
  logic         rst_n;
  logic [2:0]   key_n;
  opcode_e      op;
  logic [N-1:0] alu_out;
  logic         alu_z, alu_n, alu_v, alu_c;
  logic [N-1:0] res_q;
  logic [3:0]   flags_q;
  logic         done, busy;
  logic [6:0]   hex0, hex1;

  logic [3:0]   a_val, b_val;
  int           pass_cnt = 0;
  int           chk_cnt  = 0;
  int           done_cnt = 0;

  logic [6:0] seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  alu_key_sequencer #(.N(N), .DEBOUNCE_CYCLES(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .key_n   (key_n),
    .op      (op),
    .alu_out (alu_out),
    .alu_z   (alu_z),
    .alu_n   (alu_n),
    .alu_v   (alu_v),
    .alu_c   (alu_c),
    .res_q   (res_q),
    .flags_q (flags_q),
    .done    (done),
    .busy    (busy),
    .hex0    (hex0),
    .hex1    (hex1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: returns {N,Z,V,C,out}; C is carry for add/mult, borrow for sub
  function automatic logic [7:0] alu_model(input opcode_e o, input logic [3:0] a, input logic [3:0] b);
    int ai, bi, sa, sb, r, sr;
    logic c, v;
    logic [3:0] out;
    ai = int'(a); bi = int'(b);
    sa = (ai >= 8) ? ai - 16 : ai;
    sb = (bi >= 8) ? bi - 16 : bi;
    case (o)
      OP_ADD:  begin r = ai + bi; c = (r > 15);  sr = sa + sb; v = (sr > 7) || (sr < -8); end
      OP_SUB:  begin r = ai - bi; c = (ai < bi); sr = sa - sb; v = (sr > 7) || (sr < -8); end
      default: begin r = ai * bi; c = (r > 15);  v = 1'b0; end
    endcase
    out = 4'(r & 15);
    return {out[3], out == 4'd0, v, c, out};
  endfunction

  always_comb {alu_n, alu_z, alu_v, alu_c, alu_out} = alu_model(op, a_val, b_val);

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  function automatic logic [6:0] exp_hex0(input logic [3:0] r);
    int v;
    v = int'(r);
`ifdef ALU_SEQ_SIGNED_DISPLAY_EN
    if (v >= 8) v = (16 - v) % 16;
`endif
    return seg_tab[v];
  endfunction

  function automatic logic [6:0] exp_hex1(input logic [3:0] r);
`ifdef ALU_SEQ_SIGNED_DISPLAY_EN
    if (r >= 4'd8) return 7'b0111111;
`endif
    return 7'b1111111;
  endfunction

  function automatic opcode_e exp_op(input logic [2:0] mask);
    if (mask[2]) return OP_ADD;
    if (mask[1]) return OP_SUB;
    return OP_MULT;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_release(input logic [2:0] mask, input int hold);
    key_n = ~mask;
    cyc(hold);
    key_n = 3'b111;
    cyc(15);
  endtask

  task automatic check_capture(input string tag, input opcode_e eo);
    logic [7:0] m;
    m = alu_model(eo, a_val, b_val);
    check({tag, "_op"},    32'(op),      32'(eo));
    check({tag, "_res"},   32'(res_q),   32'(m[3:0]));
    check({tag, "_flags"}, 32'(flags_q), 32'(m[7:4]));
    check({tag, "_hex0"},  32'(hex0),    32'(exp_hex0(m[3:0])));
    check({tag, "_hex1"},  32'(hex1),    32'(exp_hex1(m[3:0])));
  endtask

  initial begin
    int d0;
    logic [2:0] mask, gl;
    bit seen;

    rst_n = 1'b0; key_n = 3'b111; a_val = 4'd3; b_val = 4'd2;
    cyc(3);
    check("rst_op",    32'(op),      32'(OP_ADD));
    check("rst_res",   32'(res_q),   32'd0);
    check("rst_flags", 32'(flags_q), 32'd0);
    check("rst_busy",  32'(busy),    32'd0);
    check("rst_done",  32'(done),    32'd0);
    check("rst_hex0",  32'(hex0),    32'(7'b1000000));
    check("rst_hex1",  32'(hex1),    32'(7'b1111111));
    rst_n = 1'b1;
    cyc(5);
    check("idle_busy", 32'(busy), 32'd0);

    // Sub: 3-2
    d0 = done_cnt;
    key_n = 3'b101;
    cyc(20);
    check("sub_done_once", 32'(done_cnt - d0), 32'd1);
    check("sub_busy_held", 32'(busy), 32'd1);
    check_capture("sub", OP_SUB);
    check("sub_res_const", 32'(res_q), 32'd1);
    check("sub_hex0_const", 32'(hex0), 32'(7'b1111001));
    key_n = 3'b111;
    cyc(15);
    check("sub_no_extra_done", 32'(done_cnt - d0), 32'd1);

    // Bounce shorter than the debounce window must be ignored
    d0 = done_cnt;
    key_n = 3'b011; cyc(3);
    key_n = 3'b111; cyc(1);
    key_n = 3'b011; cyc(3);
    key_n = 3'b111; cyc(15);
    check("bounce_no_done", 32'(done_cnt - d0), 32'd0);
    check("bounce_op_kept", 32'(op), 32'(OP_SUB));
    press_release(3'b100, 10);
    check("add10_done", 32'(done_cnt - d0), 32'd1);
    check_capture("add10", OP_ADD);
    check("add10_hex0_const", 32'(hex0), 32'(7'b0010010));

    // Simultaneous Add+Mult resolves to Add, then Mult alone
    d0 = done_cnt;
    press_release(3'b101, 20);
    check("prio_done", 32'(done_cnt - d0), 32'd1);
    check_capture("prio", OP_ADD);
    press_release(3'b001, 20);
    check_capture("mult", OP_MULT);
    check("mult_res_const", 32'(res_q), 32'd6);

    // Second key pressed while first is held is ignored
    d0 = done_cnt;
    key_n = 3'b110; cyc(15);
    key_n = 3'b010; cyc(15);
    key_n = 3'b111; cyc(15);
    check("second_key_done", 32'(done_cnt - d0), 32'd1);
    check("second_key_op", 32'(op), 32'(OP_MULT));

    // 2-3 = -1: negative with borrow
    a_val = 4'd2; b_val = 4'd3;
    press_release(3'b010, 20);
    check_capture("neg", OP_SUB);
    check("neg_res_const",   32'(res_q),   32'hF);
    check("neg_flags_const", 32'(flags_q), 32'(4'b1001));

    // Randomised presses with a short bounce ahead of each
    for (int i = 0; i < 12; i++) begin
      a_val = 4'($urandom_range(15, 0));
      b_val = 4'($urandom_range(15, 0));
      mask  = 3'($urandom_range(7, 1));
      gl    = 3'b001 << $urandom_range(2, 0);
      d0 = done_cnt;
      key_n = ~gl; cyc($urandom_range(3, 1));
      key_n = 3'b111; cyc(2);
      press_release(mask, $urandom_range(20, 10));
      check($sformatf("rnd%0d_done", i), 32'(done_cnt - d0), 32'd1);
      check_capture($sformatf("rnd%0d", i), exp_op(mask));
    end

    // Most negative value
    a_val = 4'd0; b_val = 4'd8;
    press_release(3'b010, 20);
    check_capture("minval", OP_SUB);

    // Reset while in SETTLE: no capture, back to reset values
    a_val = 4'd3; b_val = 4'd2;
    d0 = done_cnt;
    seen = 1'b0;
    key_n = 3'b101;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) begin seen = 1'b1; break; end
    end
    check("settle_reached", 32'(seen), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy),  32'd0);
    check("midrst_res",  32'(res_q), 32'd0);
    check("midrst_op",   32'(op),    32'(OP_ADD));
    key_n = 3'b111;
    cyc(2);
    rst_n = 1'b1;
    cyc(15);
    check("midrst_no_done", 32'(done_cnt - d0), 32'd0);
    check("midrst_idle",    32'(busy),  32'd0);
    check("midrst_res2",    32'(res_q), 32'd0);
    check("midrst_hex0",    32'(hex0),  32'(7'b1000000));

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
